add8_rr_sched: RTL and testbench

- Round-robin scheduler that shares one exact 8-bit adder (9-bit sum, carry out on bit 8) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one per cycle, registers the sum, and returns it on a single response channel tagged with the requester id.
- Sits between the approximate/exact adder library instance and the client blocks that time-share it.

---
 rtl/add8_rr_sched_if.sv | 34 +++
 rtl/add8_rr_sched.sv | 135 +++++++++++++
 tb/tb_add8_rr_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/add8_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : add8_rr_sched_if
// Brief    : Requester and response bundle for the shared 8-bit adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface add8_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [8:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [CNTW-1:0]   grant_cnt;

    // Client side: requesters plus the response consumer.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, grant_cnt
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, grant_cnt
    );
endinterface
`default_nettype wire

// File: rtl/add8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : add8_rr_sched
// Brief    : Round-robin scheduler time-sharing one exact 8-bit adder among
//            NREQ requesters, with a one-deep registered response slot.
// Revision : 1.0 - initial release
// ============================================================================
module add8_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    add8_rr_sched_if.slave      bus
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      sum_q,   sum_d;
    logic [IDW-1:0]  id_q,    id_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;

    logic            w_slot_free;
    logic            w_found;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_cand;
    int              w_j;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;
    logic [7:0]      w_a;
    logic [7:0]      w_b;

    assign w_slot_free = (state_q == S_EMPTY) || bus.rsp_ready;

    // Rotating priority search: first valid requester at or after ptr_q.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(ptr_q) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            w_cand = IDW'(w_j);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_accept = w_found && w_slot_free && !rst;

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_idx] = 1'b1;
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_idx == IDW'(k)) begin
                w_a = bus.req_a[8*k +: 8];
                w_b = bus.req_b[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.rsp_ready && !w_accept) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        sum_d = sum_q;
        id_d  = id_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (w_accept) begin
            sum_d = {1'b0, w_a} + {1'b0, w_b};
            id_d  = w_idx;
            ptr_d = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            sum_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (state_q == S_FULL);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
    assign bus.grant_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_add8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_add8_rr_sched
// Brief    : Scoreboard bench for add8_rr_sched (narrow counter to reach saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add8_rr_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [8:0]     sum;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;
    int   saved_cnt = 0;
    rsp_t sb[$];
    rsp_t exp_rsp;

    add8_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

    add8_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    // Scoreboard: drain the old result before queuing any same-edge accept.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            check("grant_cnt_model", bus.grant_cnt, model_cnt);
            check("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_rsp = sb.pop_front();
                    check("rsp_id", bus.rsp_id, exp_rsp.id);
                    check("rsp_sum", bus.rsp_sum, exp_rsp.sum);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_rsp.id  = IDW'(i);
                    exp_rsp.sum = {1'b0, bus.req_a[8*i +: 8]} + {1'b0, bus.req_b[8*i +: 8]};
                    sb.push_back(exp_rsp);
                    if (model_cnt != CNT_MAX) model_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset: ready must stay low even with requests pending.
        bus.req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", bus.req_ready, 4'b0000);
        rst = 1'b0;
        bus.req_valid = '0;
        tick();
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_sum", bus.rsp_sum, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_grant_cnt", bus.grant_cnt, 0);

        // Single request with full carry out.
        set_ops(0, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        check("single_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        #1;
        check("single_valid", bus.rsp_valid, 1);
        check("single_sum", bus.rsp_sum, 9'h1FE);
        check("single_id", bus.rsp_id, 0);
        check("single_cnt", bus.grant_cnt, 1);

        // Round-robin sweep from a freshly reset pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'd10);
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("sweep_ready", bus.req_ready, 4'b0001 << (k % 4));
            tick();
            check("sweep_valid", bus.rsp_valid, 1);
            check("sweep_id", bus.rsp_id, k % 4);
            check("sweep_sum", bus.rsp_sum, 10 + (k % 4));
        end

        // Wrap and skip: grant 3, then {1,2}, then only 0.
        bus.req_valid = 4'b1000;
        #1;
        check("wrap_ready3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b0110;
        #1;
        check("skip_ready1", bus.req_ready, 4'b0010);
        tick();
        #1;
        check("skip_ready2", bus.req_ready, 4'b0100);
        check("skip_id_prev", bus.rsp_id, 1);
        tick();
        bus.req_valid = 4'b0001;
        #1;
        check("wrap_ready0", bus.req_ready, 4'b0001);
        check("wrap_id_prev", bus.rsp_id, 2);
        tick();
        bus.req_valid = '0;
        #1;
        check("wrap_id0", bus.rsp_id, 0);
        tick();

        // Backpressure hold, then simultaneous drain and accept.
        bus.rsp_ready = 1'b0;
        set_ops(1, 8'h40, 8'h40);
        bus.req_valid = 4'b0010;
        #1;
        check("bp_ready1", bus.req_ready, 4'b0010);
        tick();
        saved_cnt = model_cnt;
        set_ops(2, 8'h01, 8'hFF);
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_sum", bus.rsp_sum, 9'h080);
            check("bp_id", bus.rsp_id, 1);
            check("bp_ready", bus.req_ready, 4'b0000);
            check("bp_cnt", bus.grant_cnt, saved_cnt);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.req_ready, 4'b0100);
        tick();
        #1;
        check("bp_next_valid", bus.rsp_valid, 1);
        check("bp_next_sum", bus.rsp_sum, 9'h100);
        check("bp_next_id", bus.rsp_id, 2);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;

        // Reset with an undrained result.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.rsp_valid, 0);
        check("midrst_cnt", bus.grant_cnt, 0);
        bus.rsp_ready = 1'b1;
        set_ops(1, 8'h12, 8'h34);
        bus.req_valid = 4'b1010;
        #1;
        check("midrst_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        #1;
        check("midrst_id", bus.rsp_id, 1);
        check("midrst_sum", bus.rsp_sum, 9'h046);

        // Saturation: 20 back-to-back accepts with random operands.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NREQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
            bus.req_valid = '1;
            tick();
        end
        bus.req_valid = '0;
        #1;
        check("sat_cnt", bus.grant_cnt, CNT_MAX);
        tick();
        tick();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
